// File: rtl/udp_rx_port_dispatcher_if.sv
// UDP receive-side bus: receiver header/data in, port-table config in,
// per-channel forwarded stream and statistics counters out.
interface udp_rx_port_dispatcher_if #(
  parameter int unsigned NCH = 4
);
  logic [15:0]    udp_dst_port;
  logic [15:0]    udp_src_port;
  logic [31:0]    udp_src_ip;
  logic [15:0]    udp_len;
  logic [31:0]    udp_data;
  logic           udp_data_en;
  logic           cfg_we;
  logic [2:0]     cfg_addr;
  logic [15:0]    cfg_port;
  logic           cfg_en;
  logic [31:0]    ch_data;
  logic [NCH-1:0] ch_vld;
  logic           ch_sop;
  logic           ch_eop;
  logic [1:0]     ch_mod;
  logic [15:0]    ch_len;
  logic [31:0]    ch_src_ip;
  logic [15:0]    ch_src_port;
  logic [NCH-1:0] ch_abort;
  logic [15:0]    drop_cnt;
  logic [15:0]    abort_cnt;

  // Source side: receiver plus configuration master
  modport master (
    output udp_dst_port, udp_src_port, udp_src_ip, udp_len, udp_data, udp_data_en,
    output cfg_we, cfg_addr, cfg_port, cfg_en,
    input  ch_data, ch_vld, ch_sop, ch_eop, ch_mod, ch_len, ch_src_ip, ch_src_port,
    input  ch_abort, drop_cnt, abort_cnt
  );

  // Dispatcher side
  modport slave (
    input  udp_dst_port, udp_src_port, udp_src_ip, udp_len, udp_data, udp_data_en,
    input  cfg_we, cfg_addr, cfg_port, cfg_en,
    output ch_data, ch_vld, ch_sop, ch_eop, ch_mod, ch_len, ch_src_ip, ch_src_port,
    output ch_abort, drop_cnt, abort_cnt
  );
endinterface

// File: rtl/udp_rx_port_dispatcher.sv
// Steers UDP user-data words to one of NCH channels by destination port,
// regenerating sop/eop/mod framing from the UDP length. Unmatched and
// oversize packets are dropped; stalled packets are aborted after TIMEOUT.
module udp_rx_port_dispatcher #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned MAX_LEN = 1472,
  parameter int unsigned TIMEOUT = 255
) (
  input logic                     clk,
  input logic                     rst,
  udp_rx_port_dispatcher_if.slave bus
);

  localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned REM_W = 15;
  localparam int unsigned TMR_W = 16;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t             state_q, state_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [IDX_W-1:0]   ch_q, ch_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic [15:0]        tbl_port [NCH];
  logic [NCH-1:0]     tbl_en;

  logic               hit_c;
  logic [IDX_W-1:0]   hit_idx_c;
  logic [REM_W-1:0]   nwords_c;

  logic [31:0]        data_d;
  logic [NCH-1:0]     vld_d;
  logic               sop_d;
  logic               eop_d;
  logic [1:0]         mod_d;
  logic [15:0]        len_d;
  logic [31:0]        ip_d;
  logic [15:0]        sport_d;
  logic [NCH-1:0]     abort_d;
  logic               drop_inc;
  logic               abort_inc;

  // Invalid trailing bytes in the last word for a given length residue
  function automatic logic [1:0] mod_of(input logic [1:0] res);
    return 2'(3'd4 - {1'b0, res});
  endfunction

  // Word count of the packet presented on the header lines
  assign nwords_c = REM_W'((17'(bus.udp_len) + 17'd3) >> 2);

  // Lowest enabled table entry matching the destination port
  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (!hit_c && tbl_en[i] && (tbl_port[i] == bus.udp_dst_port)) begin
        hit_c     = 1'b1;
        hit_idx_c = IDX_W'(i);
      end
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    ch_d      = ch_q;
    timer_d   = '0;
    data_d    = bus.ch_data;
    vld_d     = '0;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    mod_d     = 2'b00;
    len_d     = bus.ch_len;
    ip_d      = bus.ch_src_ip;
    sport_d   = bus.ch_src_port;
    abort_d   = '0;
    drop_inc  = 1'b0;
    abort_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.udp_data_en && (bus.udp_len != 16'd0)) begin
          if (hit_c && (bus.udp_len <= 16'(MAX_LEN))) begin
            vld_d   = NCH'(1) << hit_idx_c;
            sop_d   = 1'b1;
            data_d  = bus.udp_data;
            len_d   = bus.udp_len;
            ip_d    = bus.udp_src_ip;
            sport_d = bus.udp_src_port;
            ch_d    = hit_idx_c;
            if (nwords_c == REM_W'(1)) begin
              eop_d = 1'b1;
              mod_d = mod_of(bus.udp_len[1:0]);
            end else begin
              state_d = FWD;
              rem_d   = nwords_c - REM_W'(1);
            end
          end else begin
            drop_inc = 1'b1;
            if (nwords_c > REM_W'(1)) begin
              state_d = DROP;
              rem_d   = nwords_c - REM_W'(1);
            end
          end
        end
      end
      FWD, DROP: begin
        if (bus.udp_data_en) begin
          rem_d = rem_q - REM_W'(1);
          if (state_q == FWD) begin
            vld_d  = NCH'(1) << ch_q;
            data_d = bus.udp_data;
          end
          if (rem_q == REM_W'(1)) begin
            state_d = IDLE;
            if (state_q == FWD) begin
              eop_d = 1'b1;
              mod_d = mod_of(bus.ch_len[1:0]);
            end
          end
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          abort_inc = 1'b1;
          if (state_q == FWD) begin
            abort_d = NCH'(1) << ch_q;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and packet-context registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ch_q    <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ch_q    <= ch_d;
      timer_q <= timer_d;
    end
  end

  // Registered channel outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ch_data     <= '0;
      bus.ch_vld      <= '0;
      bus.ch_sop      <= 1'b0;
      bus.ch_eop      <= 1'b0;
      bus.ch_mod      <= 2'b00;
      bus.ch_len      <= '0;
      bus.ch_src_ip   <= '0;
      bus.ch_src_port <= '0;
      bus.ch_abort    <= '0;
    end else begin
      bus.ch_data     <= data_d;
      bus.ch_vld      <= vld_d;
      bus.ch_sop      <= sop_d;
      bus.ch_eop      <= eop_d;
      bus.ch_mod      <= mod_d;
      bus.ch_len      <= len_d;
      bus.ch_src_ip   <= ip_d;
      bus.ch_src_port <= sport_d;
      bus.ch_abort    <= abort_d;
    end
  end

  // Port table; entries at or beyond NCH are never addressed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NCH); i++) begin
        tbl_port[i] <= '0;
      end
      tbl_en <= '0;
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        if (bus.cfg_we && (bus.cfg_addr == 3'(i))) begin
          tbl_port[i] <= bus.cfg_port;
          tbl_en[i]   <= bus.cfg_en;
        end
      end
    end
  end

  // Saturating drop and abort counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.drop_cnt  <= '0;
      bus.abort_cnt <= '0;
    end else begin
      if (drop_inc && (bus.drop_cnt != 16'hFFFF)) begin
        bus.drop_cnt <= bus.drop_cnt + 16'd1;
      end
      if (abort_inc && (bus.abort_cnt != 16'hFFFF)) begin
        bus.abort_cnt <= bus.abort_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_udp_rx_port_dispatcher.sv
// Bench for udp_rx_port_dispatcher: a packet-level reference model predicts
// every channel event (cycle, channel, data, framing, header) and counters.
module tb_udp_rx_port_dispatcher;

  localparam int unsigned NCH     = 4;
  localparam int unsigned MAX_LEN = 1472;
  localparam int unsigned TIMEOUT = 255;

  typedef struct packed {
    logic [31:0]    cyc;
    logic [NCH-1:0] vld;
    logic [31:0]    data;
    logic           sop;
    logic           eop;
    logic [1:0]     mod;
    logic [15:0]    len;
    logic [31:0]    ip;
    logic [15:0]    sport;
    logic [NCH-1:0] abort;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  rec_t obs_q[$];
  rec_t exp_q[$];
  rec_t mon_r;

  // Reference model state
  int          m_port [NCH];
  bit          m_en   [NCH];
  bit          m_busy;
  bit          m_fwd;
  int          m_ch;
  int          m_left;
  int          m_idle;
  int          m_drop;
  int          m_abort;
  logic [15:0] e_len;
  logic [31:0] e_ip;
  logic [15:0] e_sport;

  udp_rx_port_dispatcher_if #(.NCH(NCH)) bus ();

  udp_rx_port_dispatcher #(
    .NCH     (NCH),
    .MAX_LEN (MAX_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle that carries a channel word or abort pulse
  always @(negedge clk) begin
    if (!rst && ((|bus.ch_vld) || (|bus.ch_abort))) begin
      mon_r.cyc   = 32'(cyc);
      mon_r.vld   = bus.ch_vld;
      mon_r.data  = (|bus.ch_vld) ? bus.ch_data : 32'd0;
      mon_r.sop   = bus.ch_sop;
      mon_r.eop   = bus.ch_eop;
      mon_r.mod   = bus.ch_mod;
      mon_r.len   = bus.ch_len;
      mon_r.ip    = bus.ch_src_ip;
      mon_r.sport = bus.ch_src_port;
      mon_r.abort = bus.ch_abort;
      obs_q.push_back(mon_r);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_port[i] = 0;
      m_en[i]   = 1'b0;
    end
    m_busy = 0; m_fwd = 0; m_ch = 0; m_left = 0; m_idle = 0;
    m_drop = 0; m_abort = 0;
    e_len = '0; e_ip = '0; e_sport = '0;
  endtask

  // Predict this cycle from the current inputs, then advance one clock
  task automatic tick();
    rec_t r;
    bit   emit;
    int   nw;
    int   hit;
    r    = '0;
    emit = 1'b0;
    r.cyc = 32'(cyc + 1);
    if (!m_busy) begin
      if (bus.udp_data_en && bus.udp_len != 16'd0) begin
        nw  = (int'(bus.udp_len) + 3) / 4;
        hit = -1;
        for (int i = 0; i < NCH; i++)
          if (hit < 0 && m_en[i] && m_port[i] == int'(bus.udp_dst_port)) hit = i;
        if (hit >= 0 && int'(bus.udp_len) <= MAX_LEN) begin
          e_len = bus.udp_len; e_ip = bus.udp_src_ip; e_sport = bus.udp_src_port;
          r.vld = NCH'(1) << hit; r.sop = 1'b1; r.data = bus.udp_data; emit = 1'b1;
          if (nw == 1) begin
            r.eop = 1'b1;
            r.mod = 2'((4 - int'(e_len) % 4) % 4);
          end else begin
            m_busy = 1; m_fwd = 1; m_ch = hit; m_left = nw - 1; m_idle = 0;
          end
        end else begin
          if (m_drop < 65535) m_drop++;
          if (nw > 1) begin
            m_busy = 1; m_fwd = 0; m_left = nw - 1; m_idle = 0;
          end
        end
      end
    end else if (bus.udp_data_en) begin
      m_idle = 0;
      if (m_fwd) begin
        r.vld = NCH'(1) << m_ch; r.data = bus.udp_data; emit = 1'b1;
      end
      if (m_left == 1) begin
        if (m_fwd) begin
          r.eop = 1'b1;
          r.mod = 2'((4 - int'(e_len) % 4) % 4);
        end
        m_busy = 0;
      end
      m_left--;
    end else begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_busy = 0;
        if (m_abort < 65535) m_abort++;
        if (m_fwd) begin
          r.abort = NCH'(1) << m_ch; emit = 1'b1;
        end
      end
    end
    if (bus.cfg_we && bus.cfg_addr < NCH) begin
      m_port[int'(bus.cfg_addr)] = int'(bus.cfg_port);
      m_en[int'(bus.cfg_addr)]   = bus.cfg_en;
    end
    r.len = e_len; r.ip = e_ip; r.sport = e_sport;
    if (emit) exp_q.push_back(r);
    @(posedge clk);
    #1;
    bus.udp_data_en = 1'b0;
    bus.cfg_we      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic cfg_write(input int addr, input int port, input bit en);
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'(addr); bus.cfg_port = 16'(port); bus.cfg_en = en;
    tick();
  endtask

  // Send a packet; n_send < 0 sends all words, otherwise stops early
  task automatic send_pkt(input int dst, input int len, input int max_gap, input int n_send);
    int nw;
    nw = (len == 0) ? 1 : (len + 3) / 4;
    if (n_send >= 0 && n_send < nw) nw = n_send;
    bus.udp_dst_port = 16'(dst);
    bus.udp_len      = 16'(len);
    bus.udp_src_port = 16'($urandom);
    bus.udp_src_ip   = $urandom;
    for (int w = 0; w < nw; w++) begin
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) tick();
      bus.udp_data = $urandom; bus.udp_data_en = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.ch_data, bus.ch_vld, bus.ch_sop, bus.ch_eop, bus.ch_mod, bus.ch_len,
         bus.ch_src_ip, bus.ch_src_port, bus.ch_abort} !== '0) begin
      fails++; $display("FAIL reset_outputs got vld=%b data=%h len=%0d expected all zero",
                        bus.ch_vld, bus.ch_data, bus.ch_len);
    end
    tests++;
    if ({bus.drop_cnt, bus.abort_cnt} !== 32'd0) begin
      fails++; $display("FAIL reset_counters got drop=%0d abort=%0d expected 0 0", bus.drop_cnt, bus.abort_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    cfg_write(1, 5000, 1'b1);
    send_pkt(5000, 10, 0, -1);
    idle(3);
    tests++;
    if (obs_q.size() != 3 || obs_q[0].vld !== 4'b0010 || !obs_q[0].sop || obs_q[2].eop !== 1'b1 ||
        obs_q[2].mod !== 2'b10 || obs_q[2].len !== 16'd10) begin
      fails++; $display("FAIL basic_framing got n=%0d expected 3 words ch1 sop..eop mod=10 len=10", obs_q.size());
    end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL basic_nrec got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL basic_rec%0d got %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_drop();
    send_pkt(6000, 20, 0, -1);
    idle(2);
    tests++;
    if (obs_q.size() != 0 || bus.drop_cnt !== 16'd1) begin
      fails++; $display("FAIL drop_unmatched got n=%0d drop=%0d expected 0 words drop=1", obs_q.size(), bus.drop_cnt);
    end
    send_pkt(5000, 7, 2, -1);
    idle(3);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL drop_nrec got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL drop_rec%0d got %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    tests++;
    if (bus.drop_cnt !== 16'(m_drop)) begin
      fails++; $display("FAIL drop_cnt got %0d expected %0d", bus.drop_cnt, m_drop);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_priority();
    cfg_write(0, 7, 1'b1);
    cfg_write(2, 7, 1'b1);
    send_pkt(7, 4, 0, -1);
    idle(2);
    tests++;
    if (obs_q.size() != 1 || obs_q[0].vld !== 4'b0001 || !obs_q[0].sop || !obs_q[0].eop ||
        obs_q[0].mod !== 2'b00) begin
      fails++; $display("FAIL prio_lowest got n=%0d expected one sop+eop word on ch0 mod=00", obs_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL prio_rec%0d got %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    send_pkt(5000, 16, 0, 2);
    idle(TIMEOUT + 5);
    tests++;
    if (obs_q.size() != 3 || obs_q[2].abort !== 4'b0010 || obs_q[1].eop !== 1'b0 ||
        bus.abort_cnt !== 16'd1) begin
      fails++; $display("FAIL timeout_abort got n=%0d abort_cnt=%0d expected 2 words + ch1 abort, abort_cnt=1",
                        obs_q.size(), bus.abort_cnt);
    end
    send_pkt(5000, 5, 1, -1);
    idle(3);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL timeout_nrec got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL timeout_rec%0d got %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_cfg_midpkt();
    bus.udp_dst_port = 16'd5000; bus.udp_len = 16'd20;
    bus.udp_src_port = 16'($urandom); bus.udp_src_ip = $urandom;
    for (int w = 0; w < 5; w++) begin
      bus.udp_data = $urandom; bus.udp_data_en = 1'b1;
      if (w == 2) begin
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd1; bus.cfg_port = 16'd5001; bus.cfg_en = 1'b1;
      end
      tick();
    end
    send_pkt(5000, 8, 0, -1);
    send_pkt(5001, 8, 0, -1);
    send_pkt(5001, 1473, 0, -1);
    send_pkt(5001, 1472, 0, -1);
    idle(3);
    tests++;
    if (obs_q.size() != 375 || obs_q[4].vld !== 4'b0010 || !obs_q[4].eop || bus.drop_cnt !== 16'd3) begin
      fails++; $display("FAIL cfg_mid got n=%0d drop=%0d expected 375 words, pkt0 ends on ch1, drop=3",
                        obs_q.size(), bus.drop_cnt);
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL cfg_mid_rec%0d got %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 20; p++)
      send_pkt((p % 3 == 0) ? 7 : 5001, $urandom_range(16, 1), 0, -1);
    idle(3);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL b2b_nrec got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL b2b_rec%0d got %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midpkt();
    send_pkt(5001, 20, 0, 2);
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    tests++;
    if ({bus.ch_data, bus.ch_vld, bus.ch_sop, bus.ch_eop, bus.ch_mod, bus.ch_len, bus.ch_src_ip,
         bus.ch_src_port, bus.ch_abort, bus.drop_cnt, bus.abort_cnt} !== '0) begin
      fails++; $display("FAIL rst_mid_outputs got vld=%b eop=%b abort=%b expected all zero",
                        bus.ch_vld, bus.ch_eop, bus.ch_abort);
    end
    bus.udp_data = $urandom; bus.udp_data_en = 1'b1;
    @(posedge clk);
    #1;
    bus.udp_data_en = 1'b0;
    rst = 1'b0;
    cfg_write(3, 9000, 1'b1);
    send_pkt(9000, 9, 0, -1);
    idle(TIMEOUT + 5);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL rst_mid_nrec got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL rst_mid_rec%0d got %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    tests++;
    if ({bus.drop_cnt, bus.abort_cnt} !== {16'(m_drop), 16'(m_abort)}) begin
      fails++; $display("FAIL rst_mid_counters got %0d/%0d expected %0d/%0d",
                        bus.drop_cnt, bus.abort_cnt, m_drop, m_abort);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int pool [4] = '{7, 5001, 9000, 6000};
    int len;
    int sel;
    for (int p = 0; p < 150; p++) begin
      if ($urandom_range(4, 0) == 0)
        cfg_write($urandom_range(7, 0), pool[$urandom_range(3, 0)], 1'($urandom_range(3, 0) != 0));
      sel = $urandom_range(19, 0);
      if (sel == 0)      len = 0;
      else if (sel == 1) len = $urandom_range(1480, 1468);
      else               len = $urandom_range(64, 1);
      if ($urandom_range(24, 0) == 0 && len > 4) begin
        send_pkt(pool[$urandom_range(3, 0)], len, 2, $urandom_range((len + 3) / 4 - 1, 1));
        idle(TIMEOUT + 2);
      end else begin
        send_pkt(pool[$urandom_range(3, 0)], len, $urandom_range(3, 0), -1);
      end
    end
    idle(4);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL rand_nrec got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL rand_rec%0d got %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    tests++;
    if ({bus.drop_cnt, bus.abort_cnt} !== {16'(m_drop), 16'(m_abort)}) begin
      fails++; $display("FAIL rand_counters got %0d/%0d expected %0d/%0d",
                        bus.drop_cnt, bus.abort_cnt, m_drop, m_abort);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    bus.udp_dst_port = '0; bus.udp_src_port = '0; bus.udp_src_ip = '0; bus.udp_len = '0;
    bus.udp_data = '0; bus.udp_data_en = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_port = '0; bus.cfg_en = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_drop();
    test_priority();
    test_timeout();
    test_cfg_midpkt();
    test_back_to_back();
    test_reset_midpkt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
